// File: rtl/mem_access_sequencer_pkg.sv
// Shared types for the memory access sequencer: access-size encodings,
// FSM state encodings, on/off constants and the store lane-merge helper.
package mem_access_sequencer_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // CPU access size; the reserved code behaves as a word access
  typedef enum logic [1:0] {
    SIZE_WORD = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_BYTE = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_WR     = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  function automatic logic is_word(input mem_size_t size);
    return (size == SIZE_WORD) || (size == SIZE_RSVD);
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    if (size == SIZE_HALF)  bad = lane[0];
    else if (is_word(size)) bad = |lane;
    return bad;
  endfunction

  // Replace the addressed little-endian lane(s) of old_word with the low bits of data
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input mem_size_t size,
                                              input logic [1:0] lane);
    logic [31:0] w;
    w = old_word;
    case (size)
      SIZE_BYTE: w[{lane, 3'b000} +: 8] = data[7:0];
      SIZE_HALF: w[{lane[1], 4'b0000} +: 16] = data[15:0];
      default:   w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Word-wide data memory bus between the sequencer (master) and memory (slave).
// Handshake: the master raises en (with we/addr/wdata stable) and holds it
// until the memory returns rdy; a phase completes on the cycle en && rdy.
// rdata is only meaningful in that completing cycle of a read phase.
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rdy;

  modport master (output en, we, addr, wdata, input rdata, rdy);
  modport slave  (input en, we, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/mem_access_sequencer_load_formatter.sv
// Combinational load formatter: picks the addressed byte/half lane of a
// memory word and sign- or zero-extends it to 32 bits.
module mem_load_formatter
  import mem_access_sequencer_pkg::*;
(
  input  mem_size_t   size,
  input  logic        extend,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select and extension; extend=0 sign-extends, extend=1 zero-extends
  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: result = {{24{~extend & byte_v[7]}}, byte_v};
      SIZE_HALF: result = {{16{~extend & half_v[15]}}, half_v};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer between CPU memory control and a word
// memory with a ready handshake. Sub-word stores are read-modify-write,
// sub-word loads are lane-extracted and extended. Every phase has a
// timeout that aborts the access with a bus_err pulse.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned
// half/word accesses with an align_err pulse instead of touching memory.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memDataSize,
  input  logic        memBitExtend,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        align_err,
  output seq_state_t  dbg_state,
  mem_access_sequencer_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  mem_size_t        req_size;
  logic             req_ext;
  logic [1:0]       req_lane;
  logic [31:0]      req_wdata;
  logic [31:0]      load_word;
  mem_size_t        size_in;

  assign size_in   = mem_size_t'(memDataSize);
  assign stall     = (memRead || memWrite) && (state != ST_DONE);
  assign dbg_state = state;

  mem_load_formatter u_fmt (
    .size   (req_size),
    .extend (req_ext),
    .lane   (req_lane),
    .word   (mem.rdata),
    .result (load_word)
  );

  // Sequencer FSM: request latch, memory phases, timeout abort, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      rdata     <= '0;
      bus_err   <= OFF;
      align_err <= OFF;
      mem.en    <= OFF;
      mem.we    <= OFF;
      mem.addr  <= '0;
      mem.wdata <= '0;
      req_size  <= SIZE_WORD;
      req_ext   <= 1'b0;
      req_lane  <= 2'b00;
      req_wdata <= '0;
    end else begin
      bus_err   <= OFF;
      align_err <= OFF;
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (memRead || memWrite) begin
            req_size  <= size_in;
            req_ext   <= memBitExtend;
            req_lane  <= addr[1:0];
            req_wdata <= wdata;
            mem.addr  <= addr[ADDR_W+1:2];
`ifdef MEM_ALIGN_CHECK_EN
            if (is_misaligned(size_in, addr[1:0])) begin
              state     <= ST_DONE;
              align_err <= ON;
              rdata     <= '0;
            end else
`endif
            if (memRead) begin
              state  <= ST_RD;
              mem.en <= ON;
              mem.we <= OFF;
            end else if (is_word(size_in)) begin
              state     <= ST_WR;
              mem.en    <= ON;
              mem.we    <= ON;
              mem.wdata <= wdata;
            end else begin
              state  <= ST_RMW_RD;
              mem.en <= ON;
              mem.we <= OFF;
            end
          end
        end
        ST_RD, ST_RMW_RD, ST_WR, ST_RMW_WR: begin
          if (mem.rdy) begin
            wait_cnt <= '0;
            if (state == ST_RMW_RD) begin
              // Keep en high straight into the write half of the RMW
              state     <= ST_RMW_WR;
              mem.we    <= ON;
              mem.wdata <= merge_lanes(mem.rdata, req_wdata, req_size, req_lane);
            end else begin
              state  <= ST_DONE;
              mem.en <= OFF;
              mem.we <= OFF;
              if (state == ST_RD) rdata <= load_word;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ST_DONE;
            wait_cnt <= '0;
            mem.en   <= OFF;
            mem.we   <= OFF;
            bus_err  <= ON;
            rdata    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
